mem_slave_responder: RTL
========================

// Module: mem_slave_responder
// PURPOSE
//  Memory-side responder for the 10-bit address / 8-bit data memory bus.
//  Services single-cycle write and read requests into an internal DEPTH x DATA_W array.
//  Returns read data after a fixed, programmable latency.
//  After every reset, sweeps the array to zero, keeps access statistics and flags protocol errors.
//  Sits behind the bus as the DUT that the driver/monitor agents exercise.
// PARAMETERS
//  ADDR_W   10    address width
//  DATA_W   8     data width
//  DEPTH    1024  array entries; legal range 2..2**ADDR_W
//  RD_LAT   1     read latency in cycles; legal range 1..4
//  CNT_W    16    width of the access statistics counters
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  reset      in   1       synchronous, active-high reset
//  address    in   ADDR_W  request address
//  wr_en      in   1       write request, sampled each clk edge
//  rd_en      in   1       read request, sampled each clk edge
//  wdata      in   DATA_W  write data
//  rdata      out  DATA_W  read data, qualified by rd_valid
//  rd_valid   out  1       rdata carries the response to a read request
//  ready      out  1       array initialised; requests are serviced
//  err        out  1       sticky protocol-error flag
//  err_clr    in   1       clears err (set has priority over clear in the same cycle)
//  wr_count   out  CNT_W   serviced writes, saturating
//  rd_count   out  CNT_W   serviced reads, saturating
//  coll_count out  CNT_W   cycles with wr_en&rd_en both high while ready, saturating
// BEHAVIOUR
//  Reset (sampled high at any edge, including mid-operation):
//   - rdata=0, rd_valid=0, ready=0, err=0, all counters=0.
//   - Read pipeline flushed; FSM goes to CLEAR with clr_ptr=0.
//  FSM, two states:
//   - CLEAR: each edge writes 0 to mem[clr_ptr], clr_ptr++.
//     The edge that writes DEPTH-1 moves the FSM to RUN and sets ready=1.
//     ready therefore rises exactly DEPTH edges after the first edge with reset low.
//   - RUN: stays in RUN until reset.
//  In CLEAR, any wr_en or rd_en is dropped:
//   - no array access, no counter update, no response;
//   - err is set.
//  RUN write (wr_en=1): if address<DEPTH, mem[address]<=wdata at the edge and wr_count++.
//  RUN read (rd_en=1), request sampled at edge t:
//   - rd_valid=1 and rdata valid after edge t+RD_LAT-1, i.e. for the cycle following it;
//   - rd_valid is high for one cycle per request;
//   - back-to-back reads give back-to-back responses (full throughput, in order);
//   - rd_count increments at edge t.
//  Read-after-write: a read of the same address at edge t+1 or later returns the new data.
//  Simultaneous wr_en&rd_en in RUN:
//   - both are performed; coll_count++;
//   - the read returns the pre-write (old) contents of its address;
//   - err is not set.
//  Out-of-range address (address>=DEPTH; only possible when DEPTH<2**ADDR_W):
//   - write is dropped and wr_count is unchanged;
//   - read still responds with rdata=0, rd_valid=1 and rd_count++;
//   - err is set in both cases.
//  rdata holds its last response value while rd_valid=0.
//  Counters saturate at all-ones; they never wrap.
//  err_clr=1 clears err at the edge unless a new error occurs in that same cycle.
// TESTING
//  1. Reset for 2 cycles, then release -> ready=0 for exactly 1024 cycles, then 1; every address reads 8'h00.
//  2. Write 8'hA5 @10'h3FF, then read @10'h3FF the next cycle -> after RD_LAT: rd_valid=1, rdata=8'hA5; wr_count=1, rd_count=1.
//  3. RD_LAT=3: 4 back-to-back reads @0..3 preloaded 11,22,33,44 -> rd_valid high for 4 consecutive cycles starting 3 cycles later, data 11,22,33,44 in order.
//  4. mem[5]=8'h0F, then wr_en&rd_en @5 with wdata=8'hF0 -> rdata=8'h0F, coll_count=1; a later read @5 returns 8'hF0.
//  5. wr_en during CLEAR -> no write, err=1; err_clr pulse -> err=0.
//  6. Reset asserted with reads in flight (RD_LAT=4) -> no rd_valid emerges afterwards; counters=0; CLEAR restarts from address 0.

Source files
------------

// File: rtl/mem_slave_responder.sv
// rtl/mem_slave_responder.sv - memory-side bus responder with clear sweep, read pipeline and statistics
module mem_slave_responder #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic              ready,
    output logic              err,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  coll_count
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                mem_we;
    logic [IDX_W-1:0]    mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic                in_range;
    logic [IDX_W-1:0]    addr_idx;
    logic [DATA_W-1:0]   rd_word;

    logic                rd_fire;
    logic                wr_fire;
    logic                coll_fire;
    logic                err_set;

    logic [RD_LAT-1:0]   vld_q;
    logic [DATA_W-1:0]   dat_q [RD_LAT];

    logic                err_q, err_d;
    logic [CNT_W-1:0]    wr_cnt_q, rd_cnt_q, coll_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != CNT_MAX)) begin
            return v + 1'b1;
        end
        return v;
    endfunction

    // Out-of-range addresses exist only when DEPTH is not a full power of two of ADDR_W.
    assign in_range = (32'(address) < 32'(DEPTH));
    assign addr_idx = address[IDX_W-1:0];
    // The read observes the array before any same-edge write, so a collision returns old data.
    assign rd_word  = in_range ? mem[addr_idx] : '0;

    // Next-state logic: clear sweep after reset, then request servicing in RUN.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        rd_fire   = 1'b0;
        wr_fire   = 1'b0;
        coll_fire = 1'b0;
        err_set   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q[IDX_W-1:0];
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_PTR) begin
                    state_d = ST_RUN;
                end
                // Requests arriving before the array is initialised are dropped and flagged.
                err_set   = wr_en | rd_en;
            end
            ST_RUN: begin
                rd_fire   = rd_en;
                coll_fire = wr_en & rd_en;
                if (wr_en) begin
                    if (in_range) begin
                        mem_we    = 1'b1;
                        mem_waddr = addr_idx;
                        mem_wdata = wdata;
                        wr_fire   = 1'b1;
                    end else begin
                        err_set   = 1'b1;
                    end
                end
                if (rd_en && !in_range) begin
                    err_set = 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // State and clear-pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Single write port shared by the clear sweep and bus writes; not touched during reset.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read response pipeline: stage 0 captures at the request edge, later stages shift;
    // data only moves alongside a valid so the output stage holds its last response.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_fire;
            if (rd_fire) begin
                dat_q[0] <= rd_word;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    // Sticky error: a new error in the same cycle wins over err_clr.
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (err_set) begin
            err_d = 1'b1;
        end
    end

    // Error flag and saturating access statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q      <= 1'b0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            coll_cnt_q <= '0;
        end else begin
            err_q      <= err_d;
            wr_cnt_q   <= sat_inc(wr_cnt_q, wr_fire);
            rd_cnt_q   <= sat_inc(rd_cnt_q, rd_fire);
            coll_cnt_q <= sat_inc(coll_cnt_q, coll_fire);
        end
    end

    assign rdata      = dat_q[RD_LAT-1];
    assign rd_valid   = vld_q[RD_LAT-1];
    assign ready      = (state_q == ST_RUN);
    assign err        = err_q;
    assign wr_count   = wr_cnt_q;
    assign rd_count   = rd_cnt_q;
    assign coll_count = coll_cnt_q;

endmodule
